// File: rtl/sdf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_pkg
//  Description : Shared types and constants for the SDF FFT sequencer:
//                FSM state encoding, cfg_log2n width, default stage count.
//  Revision    : 1.0  initial release
// ============================================================================
package sdf_pkg;

    // Width of the cfg_log2n port (FFT size exponent).
    localparam int CFG_W         = 4;

    // Default number of radix-2 SDF stages in the driven pipeline.
    localparam int MAX_LOG2N_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sdf_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_seq_ctrl_if
//  Description : Input sample stream of the SDF sequencer (valid/ready with
//                complex sample). master = sample source, slave = sequencer.
//  Signals     : s_valid, s_ready, s_re[WIDTH], s_im[WIDTH]
//  Revision    : 1.0  initial release
// ============================================================================
interface sdf_seq_ctrl_if #(
    parameter int WIDTH = 14
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_re;
    logic [WIDTH-1:0] s_im;

    modport master (output s_valid, output s_re, output s_im, input  s_ready);
    modport slave  (input  s_valid, input  s_re, input  s_im, output s_ready);
endinterface
`default_nettype wire

// File: rtl/sdf_tag_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_tag_delay
//  Description : DEPTH-deep shift line for the 2-bit {sof, eof} sample tags,
//                so frame markers emerge aligned to the pipeline output.
//  Ports       : clk, rst (async, active-high)
//                i_tag[1:0]  tag entering with the stage-0 enable
//                o_tag[1:0]  tag leaving DEPTH cycles later
//                o_any       some tag bit is still in flight
//  Revision    : 1.0  initial release
// ============================================================================
module sdf_tag_delay #(
    parameter int DEPTH = 22
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_tag,
    output logic      [1:0] o_tag,
    output logic            o_any
);

    logic [DEPTH-1:0][1:0] r_line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line <= '0;
        end else begin
            r_line[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_line[i] <= r_line[i-1];
            end
        end
    end

    assign o_tag = r_line[DEPTH-1];
    assign o_any = |r_line;

endmodule
`default_nettype wire

// File: rtl/sdf_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdf_seq_ctrl
//  Description : Sequencer for a radix-2 SDF FFT pipeline. Accepts a sample
//                stream, frames it into N = 2^cfg samples, drives the stage-0
//                enable/data and per-stage enables, and tags frame start/end
//                so out_sof/out_eof line up with the pipeline output.
//  Ports       : clk, rst (async, active-high)
//                cfg_log2n         FFT size exponent, legal 1..MAX_LOG2N
//                s_if (slave)      input stream s_valid/s_ready/s_re/s_im
//                pipe_en/re/im     stage-0 enable and data (latency 1)
//                stage_on          per-stage butterfly enable
//                out_sof/out_eof   frame markers at the pipeline output
//                busy, err_cfg, err_gap  status
//  Build macro : SDF_SEQ_CTRL_FLUSH_EN -- when defined, the FLUSH state pushes
//                PIPE_LAT zero samples through the pipeline to drain the tail
//                frame; otherwise FLUSH lasts a single idle cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module sdf_seq_ctrl
    import sdf_pkg::*;
#(
    parameter int WIDTH     = 14,
    parameter int MAX_LOG2N = MAX_LOG2N_DEF,
    parameter int PIPE_LAT  = 2*MAX_LOG2N
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [CFG_W-1:0]     cfg_log2n,
    sdf_seq_ctrl_if.slave             s_if,
    output logic                      pipe_en,
    output logic      [WIDTH-1:0]     pipe_re,
    output logic      [WIDTH-1:0]     pipe_im,
    output logic      [MAX_LOG2N-1:0] stage_on,
    output logic                      out_sof,
    output logic                      out_eof,
    output logic                      busy,
    output logic                      err_cfg,
    output logic                      err_gap
);

    // Count must hold N = 2^MAX_LOG2N itself.
    localparam int CNT_W = MAX_LOG2N + 1;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CFG_W-1:0]       r_cfg_q;
    logic [MAX_LOG2N-1:0]   r_stage_on;
    logic                   r_pipe_en;
    logic [WIDTH-1:0]       r_pipe_re;
    logic [WIDTH-1:0]       r_pipe_im;
    logic                   r_sof_tag;
    logic                   r_eof_tag;
    logic                   r_err_gap;
`ifdef SDF_SEQ_CTRL_FLUSH_EN
    localparam int FL_W = $clog2(PIPE_LAT + 1);
    logic [FL_W-1:0]        r_fl_cnt;
`endif

    logic                   w_cfg_legal;
    logic [CNT_W-1:0]       w_frame_n;
    logic                   w_last;
    logic                   w_ready;
    logic                   w_hs;
    logic                   w_start;
    logic                   w_eof_next;
    logic [MAX_LOG2N-1:0]   w_mask;
    logic [1:0]             w_tag_out;
    logic                   w_line_any;

    assign w_cfg_legal = (cfg_log2n != '0) && (int'(cfg_log2n) <= MAX_LOG2N);
    assign w_frame_n   = CNT_W'(1) << r_cfg_q;
    assign w_last      = (r_cnt == w_frame_n);

    // At a frame boundary the next frame re-latches cfg, so an illegal
    // cfg there must refuse the sample just as IDLE would.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:   w_ready = w_cfg_legal;
            ST_STREAM: w_ready = w_last ? w_cfg_legal : 1'b1;
            default:   w_ready = 1'b0;
        endcase
        if (rst) begin
            w_ready = 1'b0;
        end
    end

    assign w_hs       = s_if.s_valid & w_ready;
    assign w_start    = w_hs & ((r_state == ST_IDLE) | ((r_state == ST_STREAM) & w_last));
    assign w_eof_next = w_hs & ~w_start & ((r_cnt + CNT_W'(1)) == w_frame_n);

    always_comb begin
        w_mask = '0;
        for (int k = 0; k < MAX_LOG2N; k++) begin
            w_mask[k] = (k < int'(cfg_log2n));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cfg_q    <= '0;
            r_stage_on <= '0;
            r_pipe_en  <= 1'b0;
            r_pipe_re  <= '0;
            r_pipe_im  <= '0;
            r_sof_tag  <= 1'b0;
            r_eof_tag  <= 1'b0;
            r_err_gap  <= 1'b0;
`ifdef SDF_SEQ_CTRL_FLUSH_EN
            r_fl_cnt   <= '0;
`endif
        end else begin
            // Stage-0 data: accepted sample, otherwise zero (also the flush data).
            r_pipe_en <= w_hs;
            r_pipe_re <= w_hs ? s_if.s_re : '0;
            r_pipe_im <= w_hs ? s_if.s_im : '0;
            r_sof_tag <= w_start;
            r_eof_tag <= w_eof_next;
            r_err_gap <= 1'b0;

            // Frame start (from IDLE or back-to-back): config applies here only.
            if (w_start) begin
                r_cfg_q    <= cfg_log2n;
                r_cnt      <= CNT_W'(1);
                r_stage_on <= w_mask;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_last) begin
                        if (!w_start) begin
                            r_state <= ST_FLUSH;
`ifdef SDF_SEQ_CTRL_FLUSH_EN
                            r_fl_cnt <= '0;
`endif
                        end
                    end else if (s_if.s_valid) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        // Mid-frame gap: the frame is abandoned; its eof tag
                        // is never issued because the last sample never arrives.
                        r_err_gap <= 1'b1;
                        r_state   <= ST_FLUSH;
`ifdef SDF_SEQ_CTRL_FLUSH_EN
                        r_fl_cnt  <= '0;
`endif
                    end
                end
                ST_FLUSH: begin
`ifdef SDF_SEQ_CTRL_FLUSH_EN
                    r_pipe_en <= 1'b1;
                    if (r_fl_cnt == FL_W'(PIPE_LAT - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_fl_cnt <= r_fl_cnt + FL_W'(1);
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sdf_tag_delay #(
        .DEPTH (PIPE_LAT)
    ) u_tag_delay (
        .clk   (clk),
        .rst   (rst),
        .i_tag ({r_sof_tag, r_eof_tag}),
        .o_tag (w_tag_out),
        .o_any (w_line_any)
    );

    assign s_if.s_ready = w_ready;
    assign pipe_en      = r_pipe_en;
    assign pipe_re      = r_pipe_re;
    assign pipe_im      = r_pipe_im;
    assign stage_on     = r_stage_on;
    assign out_sof      = w_tag_out[1];
    assign out_eof      = w_tag_out[0];
    assign busy         = (r_state != ST_IDLE) | r_sof_tag | r_eof_tag | w_line_any;
    assign err_cfg      = (r_state == ST_IDLE) & ~w_cfg_legal & ~rst;
    assign err_gap      = r_err_gap;

endmodule
`default_nettype wire

// File: tb/tb_sdf_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdf_seq_ctrl
//  Description : Scoreboard bench for sdf_seq_ctrl (MAX_LOG2N=4, PIPE_LAT=8).
//                Stimulus pushes expected stage-0 samples; a monitor pops
//                them on pipe_en and schedules/compares frame markers.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdf_seq_ctrl;

    localparam int W   = 14;
    localparam int LAT = 8;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        bit           sof;
        bit           eof;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   cfg;
    logic         pipe_en;
    logic [W-1:0] pipe_re;
    logic [W-1:0] pipe_im;
    logic [3:0]   stage_on;
    logic         out_sof;
    logic         out_eof;
    logic         busy;
    logic         err_cfg;
    logic         err_gap;

    sdf_seq_ctrl_if #(.WIDTH(W)) sif ();

    sdf_seq_ctrl #(
        .WIDTH     (W),
        .MAX_LOG2N (4),
        .PIPE_LAT  (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_log2n (cfg),
        .s_if      (sif),
        .pipe_en   (pipe_en),
        .pipe_re   (pipe_re),
        .pipe_im   (pipe_im),
        .stage_on  (stage_on),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .busy      (busy),
        .err_cfg   (err_cfg),
        .err_gap   (err_gap)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   sof_t[$];
    int   eof_t[$];
    int   n_chk      = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    int   gap_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        bit   want_sof;
        bit   want_eof;
        cyc++;
        if (err_gap) gap_pulses++;
        if (!rst && pipe_en) begin
            if (exp_q.size() == 0) begin
                chk("pipe_en_unexpected", 32'(pipe_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pipe_data", {4'd0, pipe_re, pipe_im}, {4'd0, e.re, e.im});
                if (e.sof) sof_t.push_back(cyc + LAT);
                if (e.eof) eof_t.push_back(cyc + LAT);
            end
        end
        want_sof = (sof_t.size() > 0) && (sof_t[0] == cyc);
        want_eof = (eof_t.size() > 0) && (eof_t[0] == cyc);
        if (want_sof || out_sof) chk("out_sof", 32'(out_sof), 32'(want_sof));
        if (want_eof || out_eof) chk("out_eof", 32'(out_eof), 32'(want_eof));
        if (want_sof) void'(sof_t.pop_front());
        if (want_eof) void'(eof_t.pop_front());
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int re, input int im, input bit sof, input bit eof);
        exp_t e;
        sif.s_valid = 1'b1;
        sif.s_re    = W'(re);
        sif.s_im    = W'(im);
        e.re = W'(re); e.im = W'(im); e.sof = sof; e.eof = eof;
        exp_q.push_back(e);
        @(negedge clk);
        chk("s_ready", 32'(sif.s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sif.s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_flush();
`ifdef SDF_SEQ_CTRL_FLUSH_EN
        exp_t e;
        e.re = '0; e.im = '0; e.sof = 1'b0; e.eof = 1'b0;
        for (int i = 0; i < LAT; i++) exp_q.push_back(e);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] bad_cfg [2];
        bad_cfg[0] = 4'd0;
        bad_cfg[1] = 4'd5;

        rst = 1'b1; cfg = 4'd3;
        sif.s_valid = 1'b0; sif.s_re = '0; sif.s_im = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pipe_en",  32'(pipe_en),  32'd0);
        chk("rst_stage_on", 32'(stage_on), 32'd0);
        chk("rst_status",   {29'd0, busy, err_cfg, err_gap}, 32'd0);
        chk("rst_markers",  {30'd0, out_sof, out_eof}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_ready", 32'(sif.s_ready), 32'd1);

        // Illegal configurations refuse samples and flag err_cfg.
        for (int k = 0; k < 2; k++) begin
            cfg = bad_cfg[k];
            sif.s_valid = 1'b1;
            #1;
            chk("bad_cfg_err",   32'(err_cfg),     32'd1);
            chk("bad_cfg_ready", 32'(sif.s_ready), 32'd0);
            repeat (3) @(posedge clk);
            #1;
        end
        sif.s_valid = 1'b0;
        cfg = 4'd3;
        #1;
        chk("good_cfg_err", 32'(err_cfg), 32'd0);

        // Single N=8 frame.
        for (int i = 0; i < 8; i++) begin
            drive(i + 1, 16'h40 + i, i == 0, i == 7);
            if (i == 0) chk("stage_on_n8", 32'(stage_on), 32'h7);
            if (i == 4) chk("busy_stream", 32'(busy), 32'd1);
        end
        push_flush();
        idle(24);
        chk("busy_after_n8", 32'(busy), 32'd0);
        chk("stage_on_hold", 32'(stage_on), 32'h7);

        // Back-to-back frames, cfg 3->2 changed during frame 1.
        cfg = 4'd3;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) cfg = 4'd2;
            drive(16'h100 + i, 16'h200 + i, i == 0, i == 7);
            if (i == 5) chk("stage_on_f1", 32'(stage_on), 32'h7);
        end
        for (int i = 0; i < 4; i++) begin
            drive(16'h300 + i, 16'h3F0 - i, i == 0, i == 3);
            if (i == 0) chk("stage_on_f2", 32'(stage_on), 32'h3);
        end
        push_flush();
        idle(24);
        chk("busy_after_b2b", 32'(busy), 32'd0);

        // Mid-frame gap after sample 5 of 8.
        cfg = 4'd3;
        gap_pulses = 0;
        for (int i = 0; i < 5; i++) drive(16'h500 + i, 16'h50 + i, i == 0, 1'b0);
        push_flush();
        idle(24);
        chk("gap_pulses",     32'(gap_pulses),  32'd1);
        chk("gap_idle_ready", 32'(sif.s_ready), 32'd1);
        chk("gap_busy",       32'(busy),        32'd0);

        // N=2 frame: sof and eof on consecutive cycles.
        cfg = 4'd1;
        drive(16'h0AA, 16'h055, 1'b1, 1'b0);
        chk("stage_on_n2", 32'(stage_on), 32'h1);
        drive(16'h0BB, 16'h066, 1'b0, 1'b1);
        push_flush();
        idle(24);

        // Reset at sample 3.
        cfg = 4'd3;
        for (int i = 0; i < 3; i++) drive(16'h700 + i, 16'h70 + i, i == 0, 1'b0);
        rst = 1'b1;
        sif.s_valid = 1'b0;
        exp_q.delete();
        sof_t.delete();
        eof_t.delete();
        #1;
        chk("mrst_pipe", {17'd0, pipe_en, pipe_re}, 32'd0);
        chk("mrst_stage_on", 32'(stage_on), 32'd0);
        chk("mrst_status", {27'd0, busy, err_cfg, err_gap, out_sof, out_eof}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(24);
        chk("post_rst_busy", 32'(busy), 32'd0);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("sof_drained",   32'(sof_t.size()), 32'd0);
        chk("eof_drained",   32'(eof_t.size()), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
